// File: rtl/mux_select_sequencer_pkg.sv
// Shared constants and helpers for the mux select sequencer and its rate divider.
package mux_select_sequencer_pkg;

  localparam int SEL_W               = 2;
  localparam int NUM_CH              = 4;
  localparam int DEF_RATE_DIV        = 50000000;
  localparam int DEF_CNT_W           = 26;
  localparam int DEF_SYNC_STAGES     = 2;

  // Raw switch/button bundle, carried through the synchroniser as one word.
  typedef struct packed {
    logic       step_n;
    logic       hold;
    logic       mode;
    logic [3:0] data;
  } ctl_in_t;

  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(NUM_CH - 1)) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/mux_select_sequencer_rate_divider.sv
// Down-counting rate divider: one-cycle tick every RATE_DIV enabled cycles.
module mux_select_sequencer_rate_divider #(
  parameter int RATE_DIV = 4,
  parameter int CNT_W    = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(RATE_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == '0);

  // clear wins over enable so a mode change always restarts a full period
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)      count <= RELOAD;
    else if (clear)   count <= RELOAD;
    else if (tick)    count <= RELOAD;
    else if (enable)  count <= count - 1'b1;
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Synchronises raw switches and steps the 2-bit mux select manually or on a rate tick.
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter int RATE_DIV    = DEF_RATE_DIV,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [3:0]       data_in,
  input  logic             mode,
  input  logic             hold,
  input  logic             step_n,
  output logic [3:0]       data_out,
  output logic [SEL_W-1:0] sel,
  output logic             sel_strobe
);

  ctl_in_t raw;
  ctl_in_t sync_q [SYNC_STAGES];
  ctl_in_t sync_s;

  assign raw = {step_n, hold, mode, data_in};

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)     sync_q[g] <= '0;
      else if (g == 0) sync_q[g] <= raw;
      else             sync_q[g] <= sync_q[(g == 0) ? 0 : g - 1];
    end
  end

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign data_out = sync_s.data;

  // step_prev resets low, so an idle-high button after reset gives no pulse
  logic step_prev;
  logic step_pulse;
  logic tick;
  logic advance;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) step_prev <= 1'b0;
    else         step_prev <= sync_s.step_n;
  end

  assign step_pulse = step_prev & ~sync_s.step_n;

  mux_select_sequencer_rate_divider #(
    .RATE_DIV (RATE_DIV),
    .CNT_W    (CNT_W)
  ) u_rate_divider (
    .clock  (clock),
    .resetn (resetn),
    .enable (sync_s.mode & ~sync_s.hold),
    .clear  (~sync_s.mode),
    .tick   (tick)
  );

  assign advance = ~sync_s.hold & (sync_s.mode ? tick : step_pulse);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sel        <= '0;
      sel_strobe <= 1'b0;
    end else begin
      sel_strobe <= advance;
      if (advance) sel <= next_sel(sel);
    end
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer with RATE_DIV=4, SYNC_STAGES=2.
module tb_mux_select_sequencer;

  logic       clock;
  logic       resetn;
  logic [3:0] data_in;
  logic       mode;
  logic       hold;
  logic       step_n;
  logic [3:0] data_out;
  logic [1:0] sel;
  logic       sel_strobe;

  int errors;
  int checks;

  mux_select_sequencer #(
    .RATE_DIV    (4),
    .CNT_W       (3),
    .SYNC_STAGES (2)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .data_in    (data_in),
    .mode       (mode),
    .hold       (hold),
    .step_n     (step_n),
    .data_out   (data_out),
    .sel        (sel),
    .sel_strobe (sel_strobe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  // Edges counted from reset release: advances at 6,10,14,18.
  task automatic run_auto(input int d);
    int es;
    int st;
    es = 0;
    for (int e = 1; e <= 19; e++) begin
      step_clk();
      st = (e == 6 || e == 10 || e == 14 || e == 18) ? 1 : 0;
      es = (es + st) % 4;
      chk("auto_sel", int'(sel), es);
      chk("auto_strobe", int'(sel_strobe), st);
      chk("auto_data_out", int'(data_out), (e >= 2) ? d : 0);
    end
  endtask

  // Press lands at edge+1, sel moves at edge+3 after driving low.
  task automatic press(input int old, input int low_cycles);
    int strobes;
    int nxt;
    strobes = 0;
    nxt = (old + 1) % 4;
    step_n = 1'b0;
    for (int i = 1; i <= low_cycles; i++) begin
      step_clk();
      strobes += int'(sel_strobe);
      if (i == 2) chk("press_sel_before", int'(sel), old);
      if (i == 3) chk("press_sel_after", int'(sel), nxt);
    end
    step_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step_clk();
      strobes += int'(sel_strobe);
    end
    chk("press_strobe_count", strobes, 1);
    chk("press_sel_final", int'(sel), nxt);
  endtask

  initial begin
    int exp_sel;
    int exp_st;
    errors  = 0;
    checks  = 0;
    resetn  = 1'b0;
    data_in = 4'hF;
    mode    = 1'b1;
    hold    = 1'b0;
    step_n  = 1'b1;

    // reset state
    #23;
    chk("reset_sel", int'(sel), 0);
    chk("reset_strobe", int'(sel_strobe), 0);
    chk("reset_data_out", int'(data_out), 0);
    @(negedge clock);
    resetn = 1'b1;

    // auto scan from power-up
    run_auto(15);

    // manual stepping
    mode = 1'b0;
    repeat (5) step_clk();
    chk("manual_idle_sel", int'(sel), 0);
    press(0, 4);
    press(1, 4);
    press(2, 4);
    press(3, 20);

    // hold, mode switch and ignored step in auto
    mode = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      step_clk();
      if (e < 16)      exp_sel = 0;
      else if (e < 27) exp_sel = 1;
      else if (e < 31) exp_sel = 2;
      else             exp_sel = 3;
      exp_st = (e == 16 || e == 27 || e == 31) ? 1 : 0;
      chk("hold_mode_sel", int'(sel), exp_sel);
      chk("hold_mode_strobe", int'(sel_strobe), exp_st);
      if (e == 1)  data_in = 4'hA;
      if (e == 2)  hold = 1'b1;
      if (e == 12) hold = 1'b0;
      if (e == 16) mode = 1'b0;
      if (e == 21) mode = 1'b1;
      if (e == 27) step_n = 1'b0;
      if (e == 29) step_n = 1'b1;
    end
    chk("data_out_follows", int'(data_out), 10);

    // reset mid-scan
    for (int e = 32; e <= 43; e++) step_clk();
    chk("pre_reset_sel", int'(sel), 2);
    chk("pre_reset_strobe", int'(sel_strobe), 1);
    #3;
    resetn = 1'b0;
    #1;
    chk("midreset_sel", int'(sel), 0);
    chk("midreset_strobe", int'(sel_strobe), 0);
    chk("midreset_data_out", int'(data_out), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    run_auto(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
